seq_shifter: RTL and testbench
==============================

SEQ_SHIFTER -- requirements
Module: seq_shifter

Interface
REQ-001 The block SHALL have parameter NBIT, default 16, giving the operand/result width (legal: power of two, 8..64).
REQ-002 The block SHALL have parameter STEP, default 1, giving the maximum bits shifted per cycle (legal: power of two, 1..NBIT/2).
REQ-003 The block SHALL have localparam AW = clog2(NBIT), giving the shift-amount width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: request a new shift operation.
REQ-007 The block SHALL have port operand, input, NBIT bits: the value to shift, sampled with start.
REQ-008 The block SHALL have port amount, input, AW bits: the shift distance 0..NBIT-1, sampled with start.
REQ-009 The block SHALL have port mode, input, 3 bits: the operation, sampled with start.
REQ-010 The block SHALL have port ready, output, 1 bit: high when start will be accepted.
REQ-011 The block SHALL have port busy, output, 1 bit: high while a shift is in progress.
REQ-012 The block SHALL have port done, output, 1 bit: a one-cycle pulse when result is valid.
REQ-013 The block SHALL have port result, output, NBIT bits: the shifted value, held stable from done until the next accepted start.

Function
REQ-014 Mode encoding SHALL be: 000 SLL (zero fill), 001 SRL (zero fill), 010 SRA (sign fill from operand MSB), 011 ROL, 100 ROR; codes 101..111 SHALL pass operand through unchanged with normal timing.
REQ-015 The FSM SHALL have three states, IDLE, SHIFT and DONE, with reset state IDLE.
REQ-016 In IDLE or DONE, start=1 SHALL load the working register with operand, remaining with amount, latch mode, and go to SHIFT.
REQ-017 In SHIFT with remaining > 0, each cycle SHALL shift the working register by k = min(STEP, remaining) per mode and subtract k from remaining.
REQ-018 In SHIFT with remaining = 0, the block SHALL copy the working register to result and go to DONE.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle; absent start, the next state SHALL be IDLE.
REQ-020 Latency SHALL be ceil(amount/STEP)+1 rising edges from the start-accepting edge to the edge after which done is high; amount=0 gives latency 1.
REQ-021 ready SHALL equal (state != SHIFT), and busy SHALL equal (state == SHIFT).
REQ-022 start SHALL be ignored while busy; operand, amount and mode SHALL be don't-care when start is not accepted.
REQ-023 Back-to-back operation SHALL be supported: start in DONE is accepted in the same cycle done is high, with no idle bubble.
REQ-024 Rotates SHALL wrap bits modulo NBIT; SRA SHALL replicate the original operand MSB on every step.
REQ-025 The result register SHALL update only on the SHIFT-to-DONE transition.

Reset
REQ-026 Asserting rst_n low SHALL asynchronously force state=IDLE, result=0, the working register=0, remaining=0 and the latched mode=000.
REQ-027 After reset, ready SHALL be 1, and busy and done SHALL be 0.
REQ-028 Reset asserted mid-SHIFT SHALL abort the operation without asserting done; after rst_n rises, the first start SHALL behave as from power-up.

Structure
REQ-029 A shared package shift_pkg SHALL hold the mode encodings (MODE_SLL..MODE_ROR) and the FSM state encodings.
REQ-030 One sub-module shift_step SHALL implement the combinational shift of an NBIT value by k (0..STEP) for a given mode and sign bit, instantiated once.
REQ-031 No combinational path SHALL exist from the inputs to done, ready or busy.

Verification
REQ-032 The bench SHALL check: NBIT=16, STEP=1, SLL, operand 0x0001, amount 4 -> result 0x0010, done 5 edges after start, busy high for 5 cycles.
REQ-033 The bench SHALL check: SRA, operand 0x8000, amount 15, STEP=4 -> result 0xFFFF, latency 5.
REQ-034 The bench SHALL check: ROR, operand 0x00F1, amount 4 -> result 0x100F; ROL, operand 0x8001, amount 1 -> result 0x0003.
REQ-035 The bench SHALL check: amount 0, any mode -> result equals operand, done 1 edge after start; mode 111 -> passthrough.
REQ-036 The bench SHALL check: start pulsed every cycle while busy -> only the first is accepted; start in the done cycle -> second result correct with no bubble.
REQ-037 The bench SHALL check: rst_n driven low during SHIFT -> no done, result 0x0000, ready 1; the next SLL 0x0003 by 2 -> 0x000C.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared encodings for the sequential shifter: operation modes and FSM states.
package shift_pkg;

  localparam logic [2:0] MODE_SLL = 3'b000;
  localparam logic [2:0] MODE_SRL = 3'b001;
  localparam logic [2:0] MODE_SRA = 3'b010;
  localparam logic [2:0] MODE_ROL = 3'b011;
  localparam logic [2:0] MODE_ROR = 3'b100;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves din by k (0..STEP) bits per mode.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned NBIT = 16,
  parameter int unsigned STEP = 1,
  localparam int unsigned KW  = $clog2(STEP + 1)
) (
  input  logic [NBIT-1:0] din,
  input  logic [KW-1:0]   k,
  input  logic [2:0]      mode,
  input  logic            sign,
  output logic [NBIT-1:0] dout
);

  logic [2*NBIT-1:0] dbl_l;
  logic [2*NBIT-1:0] dbl_r;
  logic [2*NBIT-1:0] ext_r;

  // Rotates use a doubled copy so the wrapped bits fall out of one shift.
  always_comb begin
    dbl_l = {din, din} << k;
    dbl_r = {din, din} >> k;
    ext_r = {{NBIT{sign}}, din} >> k;
    dout  = din;
    case (mode)
      MODE_SLL: dout = din << k;
      MODE_SRL: dout = din >> k;
      MODE_SRA: dout = ext_r[NBIT-1:0];
      MODE_ROL: dout = dbl_l[2*NBIT-1:NBIT];
      MODE_ROR: dout = dbl_r[NBIT-1:0];
      default:  dout = din;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: shifts up to STEP bits per cycle until the requested
// distance is consumed, then presents the result with a one-cycle done pulse.
module seq_shifter
  import shift_pkg::*;
#(
  parameter int unsigned NBIT = 16,
  parameter int unsigned STEP = 1,
  localparam int unsigned AW  = $clog2(NBIT)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [NBIT-1:0] operand,
  input  logic [AW-1:0]   amount,
  input  logic [2:0]      mode,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [NBIT-1:0] result
);

  localparam int unsigned KW = $clog2(STEP + 1);

  state_e          state_q, state_d;
  logic [NBIT-1:0] wrk_q;
  logic [NBIT-1:0] wrk_step;
  logic [NBIT-1:0] res_q;
  logic [AW-1:0]   rem_q;
  logic [2:0]      mode_q;
  logic [KW-1:0]   k;
  logic            accept;

  assign accept = start && (state_q != StShift);
  assign result = res_q;

  // Per-cycle step size: min(STEP, remaining).
  always_comb begin
    if (rem_q >= AW'(STEP)) begin
      k = KW'(STEP);
    end else begin
      k = rem_q[KW-1:0];
    end
  end

  // For SRA the working MSB always still holds the original operand MSB,
  // so it doubles as the sign-fill source.
  shift_step #(
    .NBIT (NBIT),
    .STEP (STEP)
  ) u_step (
    .din  (wrk_q),
    .k    (k),
    .mode (mode_q),
    .sign (wrk_q[NBIT-1]),
    .dout (wrk_step)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StShift;
      StShift: if (rem_q == '0) state_d = StDone;
      StDone:  state_d = start ? StShift : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decode the state register only, so inputs never reach them.
  always_comb begin
    ready = (state_q != StShift);
    busy  = (state_q == StShift);
    done  = (state_q == StDone);
  end

  // Working register, remaining count, latched mode and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrk_q  <= '0;
      rem_q  <= '0;
      mode_q <= MODE_SLL;
      res_q  <= '0;
    end else begin
      if (accept) begin
        wrk_q  <= operand;
        rem_q  <= amount;
        mode_q <= mode;
      end else if (state_q == StShift && rem_q != '0) begin
        wrk_q <= wrk_step;
        rem_q <= rem_q - AW'(k);
      end
      if (state_q == StShift && rem_q == '0) begin
        res_q <= wrk_q;
      end
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: one STEP=1 and one STEP=4 instance, directed and
// random operations checked against a whole-shift arithmetic model.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s  [2];
  logic [15:0] op_s     [2];
  logic [3:0]  amt_s    [2];
  logic [2:0]  mode_s   [2];
  logic        ready_s  [2];
  logic        busy_s   [2];
  logic        done_s   [2];
  logic [15:0] result_s [2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seq_shifter #(.NBIT(16), .STEP(1)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_s[0]),
    .operand (op_s[0]),
    .amount  (amt_s[0]),
    .mode    (mode_s[0]),
    .ready   (ready_s[0]),
    .busy    (busy_s[0]),
    .done    (done_s[0]),
    .result  (result_s[0])
  );

  seq_shifter #(.NBIT(16), .STEP(4)) u_dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_s[1]),
    .operand (op_s[1]),
    .amount  (amt_s[1]),
    .mode    (mode_s[1]),
    .ready   (ready_s[1]),
    .busy    (busy_s[1]),
    .done    (done_s[1]),
    .result  (result_s[1])
  );

  task automatic check(input string tag, input string what, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s/%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
    end
  endtask

  // Whole-distance reference: one arithmetic shift or repeated 1-bit rotation.
  function automatic logic [15:0] model(input logic [2:0] md, input logic [15:0] op,
                                        input int amt);
    logic [15:0] r;
    r = op;
    case (md)
      3'd0: r = op << amt;
      3'd1: r = op >> amt;
      3'd2: r = 16'($signed(op) >>> amt);
      3'd3: for (int i = 0; i < amt; i++) r = {r[14:0], r[15]};
      3'd4: for (int i = 0; i < amt; i++) r = {r[0], r[15:1]};
      default: r = op;
    endcase
    return r;
  endfunction

  // Issue one operation on instance d and check result, latency, busy span and done width.
  task automatic do_op(input int d, input logic [2:0] md, input logic [15:0] op,
                       input logic [3:0] amt, input logic [15:0] exp_res, input string tag);
    int n;
    int bcnt;
    int step;
    int exp_lat;
    step    = (d == 0) ? 1 : 4;
    exp_lat = (int'(amt) + step - 1) / step + 1;
    @(negedge clk);
    check(tag, "ready", ready_s[d], 1);
    start_s[d] = 1'b1;
    mode_s[d]  = md;
    op_s[d]    = op;
    amt_s[d]   = amt;
    @(posedge clk);
    n    = 0;
    bcnt = 0;
    while (n < 100) begin
      @(negedge clk);
      start_s[d] = 1'b0;
      op_s[d]    = 16'($urandom);
      if (done_s[d]) break;
      if (busy_s[d]) bcnt++;
      @(posedge clk);
      n++;
    end
    check(tag, "done_seen", done_s[d], 1);
    check(tag, "result", result_s[d], exp_res);
    check(tag, "latency", n, exp_lat);
    check(tag, "busy_cycles", bcnt, exp_lat);
    @(negedge clk);
    check(tag, "done_width", done_s[d], 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [2:0]  md;
    logic [15:0] op;
    logic [3:0]  amt;
    int          d;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_s[i] = 1'b0;
      op_s[i]    = '0;
      amt_s[i]   = '0;
      mode_s[i]  = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset", "ready", ready_s[i], 1);
      check("reset", "busy", busy_s[i], 0);
      check("reset", "done", done_s[i], 0);
      check("reset", "result", result_s[i], 16'h0000);
    end
    rst_n = 1'b1;

    // Directed cases.
    do_op(0, 3'd0, 16'h0001, 4'd4, 16'h0010, "sll_1x4");
    do_op(1, 3'd2, 16'h8000, 4'd15, 16'hFFFF, "sra_step4");
    do_op(0, 3'd4, 16'h00F1, 4'd4, 16'h100F, "ror_f1x4");
    do_op(0, 3'd3, 16'h8001, 4'd1, 16'h0003, "rol_8001x1");
    do_op(1, 3'd4, 16'h00F1, 4'd4, 16'h100F, "ror_step4");
    do_op(0, 3'd1, 16'hA5A5, 4'd15, 16'h0001, "srl_max");
    for (int m = 0; m < 8; m++) begin
      do_op(m % 2, 3'(m), 16'hBEEF, 4'd0, 16'hBEEF, "amt0");
    end
    do_op(0, 3'd7, 16'h1234, 4'd5, 16'h1234, "pass111");
    do_op(1, 3'd5, 16'h8765, 4'd9, 16'h8765, "pass101");

    // start held high while busy; second op issued in the done cycle.
    @(negedge clk);
    start_s[0] = 1'b1;
    mode_s[0]  = 3'd0;
    op_s[0]    = 16'h0005;
    amt_s[0]   = 4'd3;
    @(posedge clk);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (done_s[0]) break;
      op_s[0]   = 16'($urandom);
      amt_s[0]  = 4'($urandom);
      mode_s[0] = 3'($urandom);
      @(posedge clk);
      n++;
    end
    check("b2b_first", "done_seen", done_s[0], 1);
    check("b2b_first", "result", result_s[0], 16'h0028);
    check("b2b_first", "latency", n, 4);
    mode_s[0] = 3'd3;
    op_s[0]   = 16'hC000;
    amt_s[0]  = 4'd2;
    @(posedge clk);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (n == 0) check("b2b_second", "no_bubble", busy_s[0], 1);
      start_s[0] = 1'b0;
      if (done_s[0]) break;
      @(posedge clk);
      n++;
    end
    check("b2b_second", "result", result_s[0], 16'h0003);
    check("b2b_second", "latency", n, 3);

    // Reset in the middle of a shift.
    @(negedge clk);
    start_s[0] = 1'b1;
    mode_s[0]  = 3'd0;
    op_s[0]    = 16'hFFFF;
    amt_s[0]   = 4'd10;
    @(posedge clk);
    @(negedge clk);
    start_s[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst", "busy_before", busy_s[0], 1);
    rst_n = 1'b0;
    #1;
    check("midrst", "ready", ready_s[0], 1);
    check("midrst", "busy", busy_s[0], 0);
    check("midrst", "result", result_s[0], 16'h0000);
    repeat (3) begin
      @(negedge clk);
      check("midrst", "no_done", done_s[0], 0);
    end
    rst_n = 1'b1;
    do_op(0, 3'd0, 16'h0003, 4'd2, 16'h000C, "post_rst");

    // Random operations against the model.
    for (int t = 0; t < 40; t++) begin
      d   = int'($urandom_range(0, 1));
      md  = 3'($urandom);
      op  = 16'($urandom);
      amt = 4'($urandom);
      do_op(d, md, op, amt, model(md, op, int'(amt)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
